apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-outstanding APB master bridging a simple valid/ready request port to up to four APB slaves (data memory and other peripherals). It decodes the upper address bits into a one-hot `psel`, sequences SETUP/ACCESS phases, honours `pready` wait states and returns one response pulse per request. It sits directly upstream of every APB peripheral slave in the SoC.

## Interface
- `NSLV`, 4: number of APB slaves, range 1..4.
- `DATA_W`, 16: data width.
- `PADDR_W`, 10: slave-local address width.
- `TIMEOUT_CYCLES`, 16: ACCESS wait cycles before abort. Only used with `APB_TIMEOUT_EN`.

Ports:
- `pclk`  in  1  clock; all state updates on the rising edge.
- `preset`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge accepts a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  12  bits [11:10] select the slave; bits [9:0] are the slave address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_W  read data. 0 for writes and errors.
- `rsp_err`  out  1  decode error or timeout.
- `paddr`  out  PADDR_W  APB address.
- `psel`  out  NSLV  one-hot slave select.
- `penable`, `pwrite`  out  1  APB control.
- `pwdata`  out  DATA_W  APB write data.
- `prdata_i`  in  NSLV*DATA_W  packed slave read data; slave k occupies [k*DATA_W +: DATA_W].
- `pready_i`  in  NSLV  per-slave ready.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- `req_ready` = (state == IDLE), combinational. No other input affects it.

IDLE:
- On `req_valid && req_ready`, latch `req_addr`, `req_write` and `req_wdata`.
- Slave index = `req_addr[11:10]`.
- Index < NSLV: go to SETUP.
- Index ≥ NSLV: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No `psel` is ever asserted.

SETUP:
- Drive `psel[idx]`=1 and `penable`=0.
- Drive `paddr`, `pwrite` and `pwdata` from the latched values.
- Unconditionally go to ACCESS.

ACCESS:
- `penable`=1; `psel`, `paddr`, `pwrite` and `pwdata` held stable.
- Transfer completes at a clock edge where `pready_i[idx]`=1.
- On completion, register `prdata_i[idx]` for a read, or 0 for a write, into `rsp_rdata`, set `rsp_err`=0 and go to RESP.
- On completion, `psel` and `penable` drop to 0.

RESP:
- `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- There is no response back-pressure; the requester must sample `rsp_valid`.
- `rsp_rdata` and `rsp_err` hold their values until the next response.

Other rules:
- `prdata_i` and `pready_i` of unselected slaves are ignored.
- Reset, at any time including mid-transfer: immediately go to IDLE.
  - Outputs take their reset values and no response is issued for the aborted request.
  - Reset values: `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=1.

## Timing
- Request accepted at edge T:
  - SETUP during cycle T+1.
  - ACCESS during cycle T+2.
  - With a zero-wait slave (`pready`=1), `rsp_valid` is high during T+3 and `req_ready` during T+4.
- Each wait state (`pready`=0 in ACCESS) adds one cycle.
- Minimum spacing between accepted requests is 4 cycles.
- Decode error: `rsp_valid` high during T+1, `req_ready` during T+2.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles with `pready`=0. It is cleared on entry to SETUP.
  - When the count reaches TIMEOUT_CYCLES with `pready` still 0, drop `psel`/`penable` and go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - `pready` arriving on the same edge as the timeout wins: the transfer is a normal completion.
- `APB_TIMEOUT_EN` undefined:
  - No counter; ACCESS waits indefinitely.
  - `rsp_err` is asserted only on decode error.

## Structure
- Package `apb_pkg` holds:
  - the `apb_state_t` enum (IDLE, SETUP, ACCESS, RESP);
  - constants `APB_DATA_W`=16, `APB_PADDR_W`=10, `APB_SEL_W`=2.
- Sub-module `apb_decoder`: combinational; maps `req_addr[11:10]` to one-hot select plus `dec_err`, parameterised by NSLV.

## Test plan
- Write: `req_addr`=0x005, `req_wdata`=0xBEEF, slave 0 `pready`=1 → `psel`=0001 in T+1 and T+2, `penable` only in T+2, `rsp_valid` T+3, `rsp_err`=0, `rsp_rdata`=0.
- Read: `req_addr`=0x405, slave 1 returns 0x1234 after 3 wait states → `penable` high for 4 cycles, `rsp_rdata`=0x1234 at T+6, slave 0 data ignored.
- Decode error: NSLV=2, `req_addr`=0xC00 → `psel` never asserted, `rsp_valid`/`rsp_err`=1 at T+1, `rsp_rdata`=0.
- Back-to-back: `req_valid` held with 3 writes, zero-wait slave → accepts at T, T+4, T+8; `req_ready` low otherwise.
- Reset: assert `preset` during ACCESS → `psel`/`penable` drop in the same cycle, no `rsp_valid`, `req_ready`=1 after release.
- `APB_TIMEOUT_EN`, TIMEOUT_CYCLES=16, `pready` stuck 0 → `rsp_err`=1 after 16 wait cycles; `pready` rising on cycle 16 → normal completion.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master bridge
// Holds the bridge state enum and the default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int APB_DATA_W  = 16;
    localparam int APB_PADDR_W = 10;
    localparam int APB_SEL_W   = 2;

endpackage

// File: rtl/apb_decoder.sv
// rtl/apb_decoder.sv - slave-select decoder for the APB master bridge
// Ports:
//   addr_sel  in   APB_SEL_W  upper request address bits (slave index)
//   sel       out  NSLV       one-hot slave select, all zero on decode error
//   dec_err   out  1          index does not name an existing slave
module apb_decoder
    import apb_pkg::*;
#(
    parameter int NSLV = 4
) (
    input  logic [APB_SEL_W-1:0] addr_sel,
    output logic [NSLV-1:0]      sel,
    output logic                 dec_err
);

    always_comb begin
        sel     = '0;
        dec_err = (32'(addr_sel) >= NSLV);
        for (int k = 0; k < NSLV; k++) begin
            sel[k] = (addr_sel == APB_SEL_W'(k));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready to APB master bridge
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES waits).
// Ports:
//   pclk, preset         clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_write, req_addr, req_wdata  request fields; req_addr[11:10] picks the slave
//   rsp_valid            one-cycle response pulse
//   rsp_rdata, rsp_err   response data / error flag, held until next response
//   paddr, psel, penable, pwrite, pwdata  APB master outputs (registered)
//   prdata_i, pready_i   packed per-slave read data and ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int NSLV           = 4,
    parameter int DATA_W         = APB_DATA_W,
    parameter int PADDR_W        = APB_PADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [11:0]            req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [PADDR_W-1:0]     paddr,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [DATA_W-1:0]      pwdata,
    input  logic [NSLV*DATA_W-1:0] prdata_i,
    input  logic [NSLV-1:0]        pready_i
);

    apb_state_t        state;
    logic [NSLV-1:0]   dec_sel;
    logic              dec_err;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    apb_decoder #(.NSLV(NSLV)) u_decoder (
        .addr_sel (req_addr[11:10]),
        .sel      (dec_sel),
        .dec_err  (dec_err)
    );

    assign req_ready = (state == IDLE);

    // psel stays one-hot through ACCESS, so it doubles as the mux select
    // for the addressed slave's ready and read data.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (psel[k]) begin
                sel_ready = pready_i[k];
                sel_rdata = prdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (dec_err) begin
                            // Nothing reaches the bus; answer straight away.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            psel     <= dec_sel;
                            paddr    <= req_addr[PADDR_W-1:0];
                            pwrite   <= req_write;
                            pwdata   <= req_wdata;
`ifdef APB_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_rdata <= pwrite ? '0 : sel_rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    // This edge is the TIMEOUT_CYCLES-th wait; a late pready
                    // on the same edge already took the branch above.
                    else if (32'(wait_cnt) == TIMEOUT_CYCLES - 1) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  paddr;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [31:0] prdata_i;
    logic [1:0]  pready_i;

    int total;
    int bad;

    apb_master_bridge #(
        .NSLV(2), .DATA_W(16), .PADDR_W(10), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata_i(prdata_i), .pready_i(pready_i)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        prdata_i = '0; pready_i = '0;
        tick(); tick();
        preset = 1'b0;
        tick();
        total++; if (psel !== 2'b00) begin bad++; $display("FAIL rst_psel got=%h exp=0", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", penable); end
        total++; if (pwrite !== 1'b0 || paddr !== 10'h0 || pwdata !== 16'h0) begin bad++; $display("FAIL rst_bus got=%b/%h/%h exp=0/0/0", pwrite, paddr, pwdata); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin bad++; $display("FAIL rst_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_write();
        prdata_i = {16'h7777, 16'hAAAA};
        pready_i = 2'b01;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h005; req_wdata = 16'hBEEF;
        tick();                       // edge T accepts
        req_valid = 1'b0;
        total++; if (psel !== 2'b01 || penable !== 1'b0) begin bad++; $display("FAIL wr_setup got psel=%h pen=%b exp psel=1 pen=0", psel, penable); end
        total++; if (paddr !== 10'h005 || pwrite !== 1'b1 || pwdata !== 16'hBEEF) begin bad++; $display("FAIL wr_setup_bus got=%h/%b/%h exp=005/1/beef", paddr, pwrite, pwdata); end
        total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_setup_hs got rdy=%b rv=%b exp 0/0", req_ready, rsp_valid); end
        tick();                       // T+2 ACCESS
        total++; if (psel !== 2'b01 || penable !== 1'b1) begin bad++; $display("FAIL wr_access got psel=%h pen=%b exp psel=1 pen=1", psel, penable); end
        tick();                       // T+3 RESP
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin bad++; $display("FAIL wr_resp got=%b/%b/%h exp=1/0/0000", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (psel !== 2'b00 || penable !== 1'b0) begin bad++; $display("FAIL wr_resp_bus got psel=%h pen=%b exp 0/0", psel, penable); end
        tick();                       // T+4 IDLE
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL wr_idle got rv=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_read_wait();
        int pen_cycles;
        prdata_i = {16'h1234, 16'h5555};
        pready_i = 2'b01;             // only the unselected slave is ready
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h405; req_wdata = 16'h0;
        tick();
        req_valid = 1'b0;
        total++; if (psel !== 2'b10 || paddr !== 10'h005 || pwrite !== 1'b0) begin bad++; $display("FAIL rd_setup got psel=%h addr=%h w=%b exp 2/005/0", psel, paddr, pwrite); end
        pen_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            tick();                   // T+2 .. T+5
            if (penable === 1'b1 && psel === 2'b10) pen_cycles++;
            if (c == 3) pready_i = 2'b11;
        end
        total++; if (pen_cycles != 4) begin bad++; $display("FAIL rd_penable_cycles got=%0d exp=4", pen_cycles); end
        tick();                       // T+6
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_resp got=%b/%h/%b exp=1/1234/0", rsp_valid, rsp_rdata, rsp_err); end
        total++; if (penable !== 1'b0 || psel !== 2'b00) begin bad++; $display("FAIL rd_resp_bus got pen=%b psel=%h exp 0/0", penable, psel); end
        tick();
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h1234) begin bad++; $display("FAIL rd_hold got rv=%b data=%h exp 0/1234", rsp_valid, rsp_rdata); end
        pready_i = 2'b00;
    endtask

    task automatic test_decode_error();
        int psel_seen;
        psel_seen = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'hC00;
        tick();                       // T+1
        req_valid = 1'b0;
        if (psel !== 2'b00) psel_seen++;
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0) begin bad++; $display("FAIL dec_resp got=%b/%b/%h exp=1/1/0000", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL dec_rdy_t1 got=%b exp=0", req_ready); end
        tick();                       // T+2
        if (psel !== 2'b00) psel_seen++;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin bad++; $display("FAIL dec_t2 got rdy=%b rv=%b err=%b exp 1/0/1", req_ready, rsp_valid, rsp_err); end
        total++; if (psel_seen != 0) begin bad++; $display("FAIL dec_psel got=%0d exp=0", psel_seen); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        pready_i = 2'b01;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h001;
        for (int k = 0; k <= 8; k++) begin
            req_wdata = 16'h1000 + 16'(k / 4);
            total++; if (req_ready !== (k % 4 == 0)) begin bad++; $display("FAIL b2b_ready_c%0d got=%b exp=%b", k, req_ready, (k % 4 == 0)); end
            if (k % 4 == 1) begin
                total++; if (pwdata !== 16'h1000 + 16'(k / 4)) begin bad++; $display("FAIL b2b_pwdata_c%0d got=%h exp=%h", k, pwdata, 16'h1000 + 16'(k / 4)); end
            end
            tick();
            if (rsp_valid === 1'b1) pulses++;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        pready_i = 2'b00;
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        pready_i = 2'b00;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h433; req_wdata = 16'hCAFE;
        tick();
        req_valid = 1'b0;
        tick();                       // ACCESS
        total++; if (penable !== 1'b1 || psel !== 2'b10) begin bad++; $display("FAIL rstm_access got pen=%b psel=%h exp 1/2", penable, psel); end
        #2 preset = 1'b1;
        #1;
        total++; if (psel !== 2'b00 || penable !== 1'b0) begin bad++; $display("FAIL rstm_drop got psel=%h pen=%b exp 0/0", psel, penable); end
        total++; if (paddr !== 10'h0 || pwdata !== 16'h0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstm_vals got=%h/%h/%b exp 0/0/0", paddr, pwdata, rsp_valid); end
        tick();
        preset = 1'b0;
        pready_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstm_after got pulses=%0d rdy=%b exp 0/1", pulses, req_ready); end
        pready_i = 2'b00;
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int pen_cycles;
        prdata_i = {16'h1234, 16'h5555};
        pready_i = 2'b00;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h400;
        tick();
        req_valid = 1'b0;
        pen_cycles = 0;
        for (int c = 0; c < 40 && rsp_valid !== 1'b1; c++) begin
            tick();
            if (penable === 1'b1) pen_cycles++;
        end
        total++; if (pen_cycles != 16) begin bad++; $display("FAIL to_wait_cycles got=%0d exp=16", pen_cycles); end
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0 || psel !== 2'b00) begin bad++; $display("FAIL to_resp got=%b/%b/%h/%h exp=1/1/0000/0", rsp_valid, rsp_err, rsp_rdata, psel); end
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 15) pready_i = 2'b10;
        end
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h1234) begin bad++; $display("FAIL to_late_ready got=%b/%b/%h exp=1/0/1234", rsp_valid, rsp_err, rsp_rdata); end
        pready_i = 2'b00;
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_decode_error();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
